// File: rtl/data_trans_framer.sv
// Frame-aware input framer. Accepts qualified words, tags the header word of
// each frame, buffers {first,data} in a first-word-fall-through FIFO and
// reports the length of each closed frame. The frame-marker input is named
// byte_mark because "byte" is a reserved word in SystemVerilog.
module data_trans_framer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_mark,
  input  logic [DATA_W-1:0] data_in,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_o,
  output logic              data_en,
  output logic              data_first,
  output logic [CNT_W-1:0]  frame_len,
  output logic              len_valid,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned EW = DATA_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // FSM command strobes
  logic push;
  logic push_first;
  logic cnt_load;
  logic cnt_inc;
  logic close;

  // Frame word counter
  logic [CNT_W-1:0] count;

  // FIFO storage and bookkeeping; each entry is {first, data}
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;

  logic          full;
  logic          pop;
  logic          push_ok;
  logic          drop;
  logic [AW-1:0] rd_next;
  logic [OW-1:0] occ_after_pop;
  logic [OW-1:0] occ_next;
  logic [EW-1:0] push_word;
  logic [EW-1:0] head_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: open on a header word, close when start drops
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && byte_mark) state_next = FRAME;
      FRAME:   if (!start)             state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Command decode: push/count/close strobes for the current state and inputs
  always_comb begin
    push       = 1'b0;
    push_first = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    close      = 1'b0;
    case (state)
      IDLE: begin
        // Non-header words outside a frame are silently discarded
        if (start && byte_mark) begin
          push       = 1'b1;
          push_first = 1'b1;
          cnt_load   = 1'b1;
        end
      end
      FRAME: begin
        if (start) begin
          push = 1'b1;
          if (byte_mark) begin
            // Back-to-back frames: close the old one and open a new one
            push_first = 1'b1;
            cnt_load   = 1'b1;
            close      = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end else begin
          close = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame counter (saturating) and closed-frame length report
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      frame_len <= '0;
      len_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (cnt_load) begin
        count <= CNT_W'(1);
      end else if (cnt_inc && (count != {CNT_W{1'b1}})) begin
        count <= count + CNT_W'(1);
      end
      if (close) begin
        frame_len <= count;
      end
      len_valid <= close;
      busy      <= (state_next == FRAME);
    end
  end

  // FIFO control: full-with-pop still accepts, otherwise a full push drops
  always_comb begin
    full          = (occ == OW'(DEPTH));
    pop           = data_en && out_ready;
    push_ok       = push && (!full || pop);
    drop          = push && full && !pop;
    push_word     = {push_first, data_in};
    rd_next       = rd_ptr + AW'(pop);
    occ_after_pop = occ - OW'(pop);
    occ_next      = occ_after_pop + OW'(push_ok);
    if (occ_next == '0) begin
      head_next = '0;
    end else if (push_ok && (occ_after_pop == '0)) begin
      // Word lands in an otherwise empty FIFO: it is the new head directly
      head_next = push_word;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates reads
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  // FIFO pointers, occupancy, registered head word and sticky overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      data_o     <= '0;
      data_first <= 1'b0;
      data_en    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr     <= rd_next;
      occ        <= occ_next;
      data_o     <= head_next[DATA_W-1:0];
      data_first <= head_next[DATA_W];
      data_en    <= (occ_next != '0);
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_trans_framer.sv
// Directed self-checking bench for data_trans_framer (DATA_W=8, DEPTH=16, CNT_W=8).
module tb_data_trans_framer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       byte_mark;
  logic [7:0] data_in;
  logic       out_ready;
  logic [7:0] data_o;
  logic       data_en;
  logic       data_first;
  logic [7:0] frame_len;
  logic       len_valid;
  logic       overflow;
  logic       busy;

  int checks = 0;
  int errors = 0;

  data_trans_framer #(
    .DATA_W(8),
    .DEPTH (16),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .byte_mark (byte_mark),
    .data_in   (data_in),
    .out_ready (out_ready),
    .data_o    (data_o),
    .data_en   (data_en),
    .data_first(data_first),
    .frame_len (frame_len),
    .len_valid (len_valid),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data_o"},     32'(data_o),     32'h0);
    check({tag, ".data_en"},    32'(data_en),    32'h0);
    check({tag, ".data_first"}, 32'(data_first), 32'h0);
    check({tag, ".frame_len"},  32'(frame_len),  32'h0);
    check({tag, ".len_valid"},  32'(len_valid),  32'h0);
    check({tag, ".overflow"},   32'(overflow),   32'h0);
    check({tag, ".busy"},       32'(busy),       32'h0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    byte_mark = 1'b0;
    data_in   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Two frames back to back, then close; downstream always ready
    start = 1'b1; byte_mark = 1'b1; data_in = 8'h35;
    tick();
    check("f1.w0.data",  32'(data_o),     32'h35);
    check("f1.w0.first", 32'(data_first), 32'h1);
    check("f1.w0.en",    32'(data_en),    32'h1);
    check("f1.w0.busy",  32'(busy),       32'h1);
    check("f1.w0.lv",    32'(len_valid),  32'h0);
    byte_mark = 1'b0; data_in = 8'hAF;
    tick();
    check("f1.w1.data",  32'(data_o),     32'hAF);
    check("f1.w1.first", 32'(data_first), 32'h0);
    data_in = 8'hE6;
    tick();
    check("f1.w2.data",  32'(data_o),     32'hE6);
    tick();
    check("f1.w3.data",  32'(data_o),     32'hE6);
    check("f1.w3.lv",    32'(len_valid),  32'h0);
    byte_mark = 1'b1; data_in = 8'h55;
    tick();
    check("f2.w0.data",  32'(data_o),     32'h55);
    check("f2.w0.first", 32'(data_first), 32'h1);
    check("f1.close.lv", 32'(len_valid),  32'h1);
    check("f1.close.len",32'(frame_len),  32'h4);
    check("f2.w0.busy",  32'(busy),       32'h1);
    start = 1'b0; byte_mark = 1'b0;
    tick();
    check("f2.close.lv", 32'(len_valid),  32'h1);
    check("f2.close.len",32'(frame_len),  32'h1);
    check("f2.close.busy",32'(busy),      32'h0);
    check("f2.drain.en", 32'(data_en),    32'h0);
    tick();
    check("f2.lv_pulse", 32'(len_valid),  32'h0);

    // Non-header words while idle are discarded
    start = 1'b1; byte_mark = 1'b0; data_in = 8'h11;
    tick();
    check("idle11.en",   32'(data_en),   32'h0);
    check("idle11.lv",   32'(len_valid), 32'h0);
    check("idle11.busy", 32'(busy),      32'h0);
    data_in = 8'h22;
    tick();
    check("idle22.en",   32'(data_en),   32'h0);
    check("idle22.lv",   32'(len_valid), 32'h0);
    check("idle22.busy", 32'(busy),      32'h0);
    start = 1'b0;
    tick();

    // Fill to full, then push and pop on the same edge
    out_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      byte_mark = (i == 0);
      data_in   = 8'(8'h60 + i);
      tick();
    end
    check("full.ovf",   32'(overflow),   32'h0);
    check("full.head",  32'(data_o),     32'h60);
    check("full.first", 32'(data_first), 32'h1);
    out_ready = 1'b1; byte_mark = 1'b0; data_in = 8'h70;
    tick();
    check("fullpp.head", 32'(data_o),   32'h61);
    check("fullpp.ovf",  32'(overflow), 32'h0);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("fullpp.en",   32'(data_en),    32'h1);
      check("fullpp.data", 32'(data_o),     32'(8'h61 + i));
      check("fullpp.first",32'(data_first), 32'h0);
      tick();
      if (i == 0) begin
        check("fullpp.lv",  32'(len_valid), 32'h1);
        check("fullpp.len", 32'(frame_len), 32'd17);
      end
    end
    check("fullpp.empty",   32'(data_en),  32'h0);
    check("fullpp.ovf_end", 32'(overflow), 32'h0);

    // 17-word frame into a stalled 16-deep FIFO drops the last word
    out_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 17; i++) begin
      byte_mark = (i == 0);
      data_in   = 8'(8'h40 + i);
      tick();
      check("ovf.flag", 32'(overflow), 32'(i == 16));
    end
    start = 1'b0; byte_mark = 1'b0;
    tick();
    check("ovf.lv",   32'(len_valid), 32'h1);
    check("ovf.len",  32'(frame_len), 32'd17);
    check("ovf.busy", 32'(busy),      32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf.en",    32'(data_en),    32'h1);
      check("ovf.data",  32'(data_o),     32'(8'h40 + i));
      check("ovf.first", 32'(data_first), 32'(i == 0));
      tick();
    end
    check("ovf.empty",  32'(data_en),  32'h0);
    check("ovf.sticky", 32'(overflow), 32'h1);

    // Reset in the middle of an open frame
    out_ready = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      byte_mark = (i == 0);
      data_in   = 8'(8'h81 + i);
      tick();
    end
    check("pre_rst.busy", 32'(busy),    32'h1);
    check("pre_rst.en",   32'(data_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    start = 1'b0; byte_mark = 1'b0;
    tick();
    check("rst_hold.lv", 32'(len_valid), 32'h0);
    reset = 1'b0;
    start = 1'b1; byte_mark = 1'b1; data_in = 8'h91;
    tick();
    check("post_rst.data",  32'(data_o),     32'h91);
    check("post_rst.first", 32'(data_first), 32'h1);
    check("post_rst.busy",  32'(busy),       32'h1);
    check("post_rst.lv",    32'(len_valid),  32'h0);
    byte_mark = 1'b0; data_in = 8'h92;
    tick();
    check("post_rst.hold", 32'(data_o), 32'h91);
    start = 1'b0; out_ready = 1'b1;
    tick();
    check("post_rst.lv2",  32'(len_valid),  32'h1);
    check("post_rst.len",  32'(frame_len),  32'h2);
    check("post_rst.w1",   32'(data_o),     32'h92);
    check("post_rst.f1",   32'(data_first), 32'h0);
    tick();
    check("post_rst.empty", 32'(data_en),   32'h0);
    check("post_rst.lv3",   32'(len_valid), 32'h0);

    // 300-word frame saturates the 8-bit length counter
    start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      byte_mark = (i == 0);
      data_in   = 8'(i);
      tick();
    end
    check("sat.ovf", 32'(overflow), 32'h0);
    start = 1'b0; byte_mark = 1'b0;
    tick();
    check("sat.lv",  32'(len_valid), 32'h1);
    check("sat.len", 32'(frame_len), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_trans_framer.md
DATA_TRANS_FRAMER -- requirements
Module: data_trans_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO depth in words (power of 2, >=4).
REQ-003 SHALL have parameter CNT_W, default 8, meaning frame-length counter width.
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  input-word qualifier; word accepted on edges where start=1.
REQ-008 byte  input  1  frame marker; 1 = accepted word is first (header) word of a new frame.
REQ-009 data_in  input  DATA_W  input word.
REQ-010 out_ready  input  1  downstream ready.
REQ-011 data_o  output  DATA_W  FIFO head word.
REQ-012 data_en  output  1  data_o valid (FIFO non-empty).
REQ-013 data_first  output  1  head word is first word of its frame.
REQ-014 frame_len  output  CNT_W  word count of most recently closed frame.
REQ-015 len_valid  output  1  one-cycle pulse, frame_len updated.
REQ-016 overflow  output  1  sticky: a word was dropped on full FIFO.
REQ-017 busy  output  1  frame currently open.

Function
REQ-018 Input FSM SHALL have states IDLE and FRAME; busy=1 exactly in FRAME.
REQ-019 IDLE, start=1, byte=1: push {first=1,data_in}, count<=1, go FRAME.
REQ-020 IDLE, start=1, byte=0: word discarded, no push, no flag change.
REQ-021 FRAME, start=1, byte=0: push {first=0,data_in}, count+1 saturating at 2^CNT_W-1.
REQ-022 FRAME, start=1, byte=1: close current frame and open new one same edge; push {first=1,data_in}, count<=1, stay FRAME.
REQ-023 FRAME, start=0: close frame, go IDLE.
REQ-024 On close: frame_len<=count (words accepted incl. header, dropped words included), len_valid=1 the following cycle only.
REQ-025 FIFO SHALL be first-word-fall-through: word pushed at edge N visible on data_o/data_en from edge N onward (one-cycle latency).
REQ-026 Pop SHALL occur on edge where data_en=1 and out_ready=1; data_o/data_first SHALL hold stable while data_en=1 and out_ready=0.
REQ-027 Full = DEPTH words held; push when full without concurrent pop SHALL drop the word and set overflow=1.
REQ-028 Push and pop on same edge when full SHALL both succeed; count unchanged, no overflow.
REQ-029 Push and pop on same edge when empty: pushed word becomes head after edge; data_en stays 1.
REQ-030 Pointers SHALL wrap modulo DEPTH; occupancy tracked with log2(DEPTH)+1 bits.
REQ-031 overflow SHALL clear only on reset.

Reset
REQ-032 reset=1 SHALL immediately force: FSM IDLE, FIFO empty, data_o=0, data_en=0, data_first=0, frame_len=0, len_valid=0, overflow=0, busy=0.
REQ-033 Reset mid-frame SHALL discard the open frame and buffered words; no len_valid pulse.
REQ-034 First edge after reset deassertion SHALL accept input normally.

Verification
REQ-035 out_ready=1; start=1: byte=1 0x35, byte=0 0xAF,0xE6,0xE6, byte=1 0x55, then start=0 -> data_o 35(first),AF,E6,E6,55(first); len_valid frame_len=4 after 0x55 edge, then frame_len=1 after start falls.
REQ-036 out_ready=0, DEPTH=16; one frame of 17 words -> 16 held, overflow=1, 17th word absent from output, frame_len=17.
REQ-037 FIFO full, out_ready=1, push same edge -> occupancy stays 16, overflow stays 0, order preserved.
REQ-038 IDLE, start=1, byte=0 words 0x11,0x22 -> data_en stays 0, no len_valid, busy=0.
REQ-039 Assert reset after 3 words of open frame -> all outputs 0 same cycle, no len_valid; new frame after release outputs correctly.
REQ-040 Frame of 300 words, CNT_W=8, out_ready=1 -> frame_len=255 (saturated).
